// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller and the PWM generator it feeds.
package pwm_pkg;

  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] S_RAMP_UP   = 2'd1;
  localparam logic [STATE_W-1:0] S_RAMP_DOWN = 2'd2;
  localparam logic [STATE_W-1:0] S_FAULT     = 2'd3;

  // Carrier and clock defaults shared with the PWM generator so both count the same period.
  localparam int unsigned PWM_FREQ_DEF = 25000;
  localparam int unsigned CLK_FREQ_DEF = 500000;

  typedef logic [DUTY_W-1:0] duty_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// PWM period counter and ramp step prescaler; step_en fires on the period wrap that ends a step.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD           = 20,
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_step,
  output logic tick,
  output logic step_en
);

  localparam int unsigned PW = cnt_w(PERIOD);
  localparam int unsigned SW = cnt_w(PERIODS_PER_STEP);

  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;

  always_comb begin
    tick         = (period_cnt_q == PW'(PERIOD - 1));
    step_en      = tick && (step_cnt_q == SW'(PERIODS_PER_STEP - 1));
    period_cnt_d = tick ? '0 : period_cnt_q + PW'(1);
    step_cnt_d   = step_cnt_q;
    // A clear on accept wins over a coincident tick so the first step always waits a full count.
    if (clr_step) begin
      step_cnt_d = '0;
    end else if (tick) begin
      step_cnt_d = (step_cnt_q == SW'(PERIODS_PER_STEP - 1)) ? '0 : step_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_cnt_q <= '0;
      step_cnt_q   <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty controller: ramps duty toward a commanded target on PWM period boundaries.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_FREQ         = PWM_FREQ_DEF,
  parameter int unsigned CLK_FREQ         = CLK_FREQ_DEF,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned STEP             = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              at_target
);

  localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int unsigned W9     = DUTY_W + 1;

  logic [STATE_W-1:0] state_q, state_d;
  duty_t              duty_q, duty_d;
  duty_t              target_q, target_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               at_target_q, at_target_d;

  logic               accept;
  logic               tick;
  logic               step_en;
  logic [W9-1:0]      gap_up;
  logic [W9-1:0]      gap_down;

  pwm_tick_gen #(
    .PERIOD           (PERIOD),
    .PERIODS_PER_STEP (PERIODS_PER_STEP)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clr_step (accept),
    .tick     (tick),
    .step_en  (step_en)
  );

  assign cmd_ready = (state_q == S_IDLE) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign at_target = at_target_q;

  // Distances computed in 9 bits so STEP up to 255 compares without wrap.
  assign gap_up   = W9'(target_q) - W9'(duty_q);
  assign gap_down = W9'(duty_q) - W9'(target_q);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (estop) begin
      state_d  = S_FAULT;
      duty_d   = '0;
      target_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            target_d = cmd_duty;
            if (cmd_duty > duty_q) begin
              state_d = S_RAMP_UP;
            end else if (cmd_duty < duty_q) begin
              state_d = S_RAMP_DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_RAMP_UP: begin
          if (step_en) begin
            if (gap_up <= W9'(STEP)) begin
              duty_d  = target_q;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              duty_d = duty_q + DUTY_W'(STEP);
            end
          end
        end
        S_RAMP_DOWN: begin
          if (step_en) begin
            if (gap_down <= W9'(STEP)) begin
              duty_d  = target_q;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              duty_d = duty_q - DUTY_W'(STEP);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d      = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
    at_target_d = (state_d == S_IDLE) && (duty_d == target_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      duty_q      <= '0;
      target_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
    end
  end

  // Ramp steps are only ever issued on a period wrap.
  a_step_on_wrap : assert property (@(posedge clk) disable iff (!rst) step_en |-> tick);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: command table, corner-case sequences and random traffic.
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 20;
  localparam int PPS    = 4;
  localparam int STEP   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready;
  logic       estop;
  logic [7:0] duty;
  logic       busy;
  logic       done;
  logic       at_target;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .PWM_FREQ         (25000),
    .CLK_FREQ         (500000),
    .PERIODS_PER_STEP (PPS),
    .STEP             (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_duty  (cmd_duty),
    .cmd_ready (cmd_ready),
    .estop     (estop),
    .duty      (duty),
    .busy      (busy),
    .done      (done),
    .at_target (at_target)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef enum int {M_IDLE, M_UP, M_DOWN, M_FAULT} mode_t;
  mode_t m_mode;
  int    m_duty, m_target, m_pc, m_ticks;
  bit    m_done;

  int done_cnt, chg_cnt, last_val, prev_val;
  bit busy_seen;

  typedef struct {
    int cmd;
    int exp_duty;
    int exp_steps;
    int exp_prev;
    bit exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_duty = 0; m_target = 0; m_pc = 0; m_ticks = 0; m_done = 0;
  endtask

  // Behavioural reference: one clock edge of the controller's rules.
  task automatic model_step(input bit r, input bit v, input int c, input bit e);
    bit tk;
    tk = (m_pc == PERIOD - 1);
    if (!r) begin
      model_reset();
      return;
    end
    m_pc   = (m_pc + 1) % PERIOD;
    m_done = 0;
    if (e) begin
      m_mode = M_FAULT; m_duty = 0; m_target = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (v) begin
          m_target = c;
          m_ticks  = 0;
          if (c > m_duty) m_mode = M_UP;
          else if (c < m_duty) m_mode = M_DOWN;
          else m_done = 1;
        end
        M_UP, M_DOWN: if (tk) begin
          m_ticks++;
          if (m_ticks % PPS == 0) begin
            if (m_mode == M_UP) m_duty = (m_duty + STEP > m_target) ? m_target : m_duty + STEP;
            else m_duty = (m_duty - STEP < m_target) ? m_target : m_duty - STEP;
            if (m_duty == m_target) begin
              m_mode = M_IDLE; m_done = 1;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock: drive inputs at negedge, check cmd_ready, step DUT and model, check registered outputs.
  task automatic cycle(input bit r, input bit v, input logic [7:0] c, input bit e, output bit acc);
    bit tk;
    logic [7:0] pd;
    rst = r; cmd_valid = v; cmd_duty = c; estop = e;
    #1;
    check("cmd_ready", cmd_ready, (m_mode == M_IDLE) && !e);
    acc = r && v && !e && (m_mode == M_IDLE);
    tk  = (m_pc == PERIOD - 1);
    pd  = duty;
    @(posedge clk);
    model_step(r, v, int'(c), e);
    @(negedge clk);
    check("duty", duty, m_duty);
    check("busy", busy, (m_mode == M_UP) || (m_mode == M_DOWN));
    check("done", done, m_done);
    check("at_target", at_target, (m_mode == M_IDLE) && (m_duty == m_target));
    if (duty != pd) begin
      chg_cnt++;
      prev_val = last_val;
      last_val = int'(duty);
      if (r && !e) check("change_on_wrap", tk, 1);
    end
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
  endtask

  task automatic run_cmd(input int c);
    bit acc = 0;
    done_cnt = 0; chg_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 10 && !acc; i++) cycle(1, 1, 8'(c), 0, acc);
    check("cmd_accept", acc, 1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) cycle(1, 0, 8'(c), 0, acc);
    repeat (4) cycle(1, 0, 8'(c), 0, acc);
  endtask

  task automatic wait_duty(input int v);
    bit acc;
    for (int i = 0; i < 3000 && duty != 8'(v); i++) cycle(1, 0, 8'd0, 0, acc);
    check("reach_duty", duty, v);
  endtask

  vec_t vecs[5];

  initial begin
    bit acc;
    bit pending;
    int pcmd;
    int estop_left;

    vecs[0] = '{100, 100, 13,  96, 1};
    vecs[1] = '{  0,   0, 13,   4, 1};
    vecs[2] = '{255, 255, 32, 248, 1};
    vecs[3] = '{100, 100, 20, 103, 1};
    vecs[4] = '{100, 100,  0,   0, 0};

    rst = 1'b0; cmd_valid = 1'b0; cmd_duty = 8'd0; estop = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_at_target", at_target, 1);
    check("rst_cmd_ready", cmd_ready, 1);

    foreach (vecs[k]) begin
      run_cmd(vecs[k].cmd);
      check("tbl_duty", duty, vecs[k].exp_duty);
      check("tbl_steps", chg_cnt, vecs[k].exp_steps);
      check("tbl_done_cnt", done_cnt, 1);
      check("tbl_busy_seen", busy_seen, vecs[k].exp_busy);
      if (vecs[k].exp_steps > 0) check("tbl_prev_step", prev_val, vecs[k].exp_prev);
    end

    // Emergency stop in the middle of a ramp at duty 48.
    run_cmd(0);
    cycle(1, 1, 8'd100, 0, acc);
    wait_duty(48);
    done_cnt = 0;
    cycle(1, 0, 8'd0, 1, acc);
    check("estop_duty", duty, 0);
    check("estop_busy", busy, 0);
    check("estop_no_done", done, 0);
    repeat (3) cycle(1, 0, 8'd0, 1, acc);
    check("estop_ready_low", cmd_ready, 0);
    cycle(1, 0, 8'd0, 0, acc);
    check("release_ready", cmd_ready, 1);
    check("release_duty", duty, 0);
    check("release_at_target", at_target, 1);
    check("estop_done_cnt", done_cnt, 0);

    // Command held during a ramp is taken only in the first idle cycle.
    cycle(1, 1, 8'd100, 0, acc);
    for (int i = 0; i < 3000 && !cmd_ready; i++) cycle(1, 1, 8'd30, 0, acc);
    check("held_ready_at_done", done, 1);
    check("held_duty_before", duty, 100);
    cycle(1, 1, 8'd30, 0, acc);
    check("held_accepted", acc, 1);
    check("held_busy", busy, 1);
    wait_duty(30);
    cycle(1, 0, 8'd0, 0, acc);
    check("held_final_idle", busy, 0);

    // estop and cmd_valid together: no accept.
    cycle(1, 1, 8'd200, 1, acc);
    check("estop_cmd_busy", busy, 0);
    cycle(1, 0, 8'd0, 0, acc);
    cycle(1, 0, 8'd0, 0, acc);
    check("estop_cmd_not_taken", busy, 0);
    check("estop_cmd_duty", duty, 0);

    // Reset mid-ramp at duty 64.
    cycle(1, 1, 8'd200, 0, acc);
    wait_duty(64);
    cycle(0, 0, 8'd0, 0, acc);
    check("midrst_duty", duty, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    cycle(1, 0, 8'd0, 0, acc);

    // Random traffic with a well-behaved requester.
    pending = 0; pcmd = 0; estop_left = 0;
    for (int i = 0; i < 9000; i++) begin
      bit r, e;
      if (!pending && $urandom_range(0, 5) == 0) begin
        pending = 1;
        pcmd = ($urandom_range(0, 4) == 0) ? m_duty : int'($urandom_range(0, 255));
      end
      if (estop_left == 0 && $urandom_range(0, 299) == 0) estop_left = int'($urandom_range(1, 5));
      e = (estop_left > 0);
      if (estop_left > 0) estop_left--;
      r = ($urandom_range(0, 999) != 0);
      cycle(r, pending, 8'(pcmd), e, acc);
      if (acc) pending = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
